// File: rtl/glitch_sequencer.sv
// Glitch attempt sequencer: optional target reset hold, trigger edge wait, delay,
// then a burst of glitch pulses with programmable width and gap.
module glitch_sequencer #(
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned WIDTH_W = 16,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic [WIDTH_W-1:0] cfg_width_i,
    input  logic [WIDTH_W-1:0] cfg_gap_i,
    input  logic [COUNT_W-1:0] cfg_count_i,
    input  logic [WIDTH_W-1:0] cfg_reset_len_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trigger_i,
    output logic               pulse_o,
    output logic               target_reset_o,
    output logic               busy_o,
    output logic               waiting_o,
    output logic               done_o
);

    localparam int unsigned TMR_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DELAY = 3'd3;
    localparam logic [2:0] S_PULSE = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0] left_q, left_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] gap_q, gap_d;

    logic sync1_q, sync2_q, sync3_q, trig_edge_q;
    logic pulse_d, target_reset_d, busy_d, waiting_d, done_d;

    // Two-flop synchroniser, then a registered 0->1 edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            trig_edge_q <= 1'b0;
        end else begin
            sync1_q     <= trigger_i;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            trig_edge_q <= sync2_q & ~sync3_q;
        end
    end

    // State, counters, captured configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            left_q         <= '0;
            delay_q        <= '0;
            width_q        <= '0;
            gap_q          <= '0;
            pulse_o        <= 1'b0;
            target_reset_o <= 1'b0;
            busy_o         <= 1'b0;
            waiting_o      <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            left_q         <= left_d;
            delay_q        <= delay_d;
            width_q        <= width_d;
            gap_q          <= gap_d;
            pulse_o        <= pulse_d;
            target_reset_o <= target_reset_d;
            busy_o         <= busy_d;
            waiting_o      <= waiting_d;
            done_o         <= done_d;
        end
    end

    // Next state; timers are loaded on state entry and leave the state at a count of 1
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        left_d  = left_q;
        delay_d = delay_q;
        width_d = width_q;
        gap_d   = gap_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_i && !abort_i) begin
                    delay_d = cfg_delay_i;
                    width_d = (cfg_width_i == '0) ? WIDTH_W'(1) : cfg_width_i;
                    gap_d   = (cfg_gap_i == '0) ? WIDTH_W'(1) : cfg_gap_i;
                    left_d  = (cfg_count_i == '0) ? COUNT_W'(1) : cfg_count_i;
                    if (cfg_reset_len_i != '0) begin
                        state_d = S_RESET;
                        timer_d = TMR_W'(cfg_reset_len_i);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RESET: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = S_WAIT;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_WAIT: begin
                if (trig_edge_q) begin
                    if (delay_q != '0) begin
                        state_d = S_DELAY;
                        timer_d = TMR_W'(delay_q);
                    end else begin
                        state_d = S_PULSE;
                        timer_d = TMR_W'(width_q);
                    end
                end
            end
            S_DELAY: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = S_PULSE;
                    timer_d = TMR_W'(width_q);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_PULSE: begin
                if (timer_q <= TMR_W'(1)) begin
                    if (left_q <= COUNT_W'(1)) begin
                        state_d = S_IDLE;
                        left_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        left_d  = left_q - COUNT_W'(1);
                        timer_d = TMR_W'(gap_q);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = S_PULSE;
                    timer_d = TMR_W'(width_q);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops everything without a completion strobe
        if (abort_i) begin
            state_d = S_IDLE;
            timer_d = '0;
            left_d  = '0;
            done_d  = 1'b0;
        end

        pulse_d        = (state_d == S_PULSE);
        target_reset_d = (state_d == S_RESET);
        busy_d         = (state_d != S_IDLE);
        waiting_d      = (state_d == S_WAIT);
    end

endmodule
